// File: rtl/rs_branch_pkg.sv
// Shared widths and op encodings for the branch reservation station slice.
// Widths track the RV32 core constants so the RS lines up with exunit_br.
package rs_branch_pkg;

  localparam int RS_BR_ENTRY_NUM = 4;
  localparam int RS_BR_TAG_WIDTH = 6;
  localparam int RV32_DATA_WIDTH = 32;
  localparam int RV32_PC_WIDTH   = 32;
  localparam int ALU_OP_SEL      = 4;

  typedef enum logic [ALU_OP_SEL-1:0] {
    BR_BEQ  = 4'h8,
    BR_BNE  = 4'h9,
    BR_BLT  = 4'hA,
    BR_BGE  = 4'hB,
    BR_BLTU = 4'hC,
    BR_BGEU = 4'hD
  } br_op_e;

endpackage

// File: rtl/rs_branch_if.sv
// Dispatch, CDB, flush and issue signals between the core and rs_branch.
// The slave side is the reservation station itself.
interface rs_branch_if
  import rs_branch_pkg::*;
#(
  parameter int TAG_WIDTH  = RS_BR_TAG_WIDTH,
  parameter int DATA_WIDTH = RV32_DATA_WIDTH,
  parameter int PC_WIDTH   = RV32_PC_WIDTH,
  parameter int OP_WIDTH   = ALU_OP_SEL
);

  logic                  i_dp_vld;
  logic                  o_dp_ready;
  logic                  i_dp_is_jal;
  logic                  i_dp_is_jalr;
  logic [OP_WIDTH-1:0]   i_dp_alu_op_sel;
  logic                  i_dp_src1_rdy;
  logic                  i_dp_src2_rdy;
  logic [DATA_WIDTH-1:0] i_dp_src1;
  logic [DATA_WIDTH-1:0] i_dp_src2;
  logic [TAG_WIDTH-1:0]  i_dp_src1_tag;
  logic [TAG_WIDTH-1:0]  i_dp_src2_tag;
  logic [PC_WIDTH-1:0]   i_dp_pc;
  logic [DATA_WIDTH-1:0] i_dp_imm;
  logic [PC_WIDTH-1:0]   i_dp_pred_jmpaddr;
  logic [TAG_WIDTH-1:0]  i_dp_rob_tag;

  logic                  i_cdb_vld;
  logic [TAG_WIDTH-1:0]  i_cdb_tag;
  logic [DATA_WIDTH-1:0] i_cdb_data;

  logic                  i_flush;
  logic                  i_ex_accessable;

  logic                  o_is_vld;
  logic                  o_is_jal;
  logic                  o_is_jalr;
  logic [OP_WIDTH-1:0]   o_alu_op_sel;
  logic [DATA_WIDTH-1:0] o_rs1;
  logic [DATA_WIDTH-1:0] o_rs2;
  logic [PC_WIDTH-1:0]   o_pc;
  logic [DATA_WIDTH-1:0] o_imm;
  logic [PC_WIDTH-1:0]   o_pred_jmpaddr;
  logic [TAG_WIDTH-1:0]  o_rob_tag;

  modport slave (
    input  i_dp_vld, i_dp_is_jal, i_dp_is_jalr, i_dp_alu_op_sel,
           i_dp_src1_rdy, i_dp_src2_rdy, i_dp_src1, i_dp_src2,
           i_dp_src1_tag, i_dp_src2_tag, i_dp_pc, i_dp_imm,
           i_dp_pred_jmpaddr, i_dp_rob_tag,
           i_cdb_vld, i_cdb_tag, i_cdb_data, i_flush, i_ex_accessable,
    output o_dp_ready, o_is_vld, o_is_jal, o_is_jalr, o_alu_op_sel,
           o_rs1, o_rs2, o_pc, o_imm, o_pred_jmpaddr, o_rob_tag
  );

  modport master (
    output i_dp_vld, i_dp_is_jal, i_dp_is_jalr, i_dp_alu_op_sel,
           i_dp_src1_rdy, i_dp_src2_rdy, i_dp_src1, i_dp_src2,
           i_dp_src1_tag, i_dp_src2_tag, i_dp_pc, i_dp_imm,
           i_dp_pred_jmpaddr, i_dp_rob_tag,
           i_cdb_vld, i_cdb_tag, i_cdb_data, i_flush, i_ex_accessable,
    input  o_dp_ready, o_is_vld, o_is_jal, o_is_jalr, o_alu_op_sel,
           o_rs1, o_rs2, o_pc, o_imm, o_pred_jmpaddr, o_rob_tag
  );

endinterface

// File: rtl/rs_oldest_sel.sv
// Oldest-ready picker: grants the ready entry that has no older ready entry.
// age_i[i][j] set means entry j is older than entry i.
module rs_oldest_sel
  import rs_branch_pkg::*;
#(
  parameter int ENTRY_NUM = RS_BR_ENTRY_NUM
) (
  input  logic [ENTRY_NUM-1:0]                ready_i,
  input  logic [ENTRY_NUM-1:0][ENTRY_NUM-1:0] age_i,
  output logic [ENTRY_NUM-1:0]                grant_o,
  output logic                                any_o
);

  always_comb begin
    grant_o = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      grant_o[i] = ready_i[i] & ~(|(age_i[i] & ready_i));
    end
  end

  assign any_o = |ready_i;

endmodule

// File: rtl/rs_branch.sv
// Branch reservation station: buffers branch/jump uops until both operands are
// ready, snoops the CDB, and issues the oldest ready entry to exunit_br.
module rs_branch
  import rs_branch_pkg::*;
#(
  parameter int ENTRY_NUM  = RS_BR_ENTRY_NUM,
  parameter int TAG_WIDTH  = RS_BR_TAG_WIDTH,
  parameter int DATA_WIDTH = RV32_DATA_WIDTH,
  parameter int PC_WIDTH   = RV32_PC_WIDTH,
  parameter int OP_WIDTH   = ALU_OP_SEL
) (
  input logic        clk,
  input logic        rst_n,
  rs_branch_if.slave bus
);

  logic [ENTRY_NUM-1:0]                valid_q, valid_d;
  logic [ENTRY_NUM-1:0][ENTRY_NUM-1:0] age_q, age_d;

  logic [ENTRY_NUM-1:0]  isJal_q, isJal_d, isJalr_q, isJalr_d;
  logic [ENTRY_NUM-1:0]  src1Rdy_q, src1Rdy_d, src2Rdy_q, src2Rdy_d;
  logic [OP_WIDTH-1:0]   op_q   [ENTRY_NUM];
  logic [OP_WIDTH-1:0]   op_d   [ENTRY_NUM];
  logic [DATA_WIDTH-1:0] src1_q [ENTRY_NUM];
  logic [DATA_WIDTH-1:0] src1_d [ENTRY_NUM];
  logic [DATA_WIDTH-1:0] src2_q [ENTRY_NUM];
  logic [DATA_WIDTH-1:0] src2_d [ENTRY_NUM];
  logic [TAG_WIDTH-1:0]  tag1_q [ENTRY_NUM];
  logic [TAG_WIDTH-1:0]  tag1_d [ENTRY_NUM];
  logic [TAG_WIDTH-1:0]  tag2_q [ENTRY_NUM];
  logic [TAG_WIDTH-1:0]  tag2_d [ENTRY_NUM];
  logic [PC_WIDTH-1:0]   pc_q   [ENTRY_NUM];
  logic [PC_WIDTH-1:0]   pc_d   [ENTRY_NUM];
  logic [DATA_WIDTH-1:0] imm_q  [ENTRY_NUM];
  logic [DATA_WIDTH-1:0] imm_d  [ENTRY_NUM];
  logic [PC_WIDTH-1:0]   pred_q [ENTRY_NUM];
  logic [PC_WIDTH-1:0]   pred_d [ENTRY_NUM];
  logic [TAG_WIDTH-1:0]  rob_q  [ENTRY_NUM];
  logic [TAG_WIDTH-1:0]  rob_d  [ENTRY_NUM];

  logic                  payJal_q, payJal_d, payJalr_q, payJalr_d;
  logic [OP_WIDTH-1:0]   payOp_q, payOp_d;
  logic [DATA_WIDTH-1:0] payRs1_q, payRs1_d, payRs2_q, payRs2_d;
  logic [PC_WIDTH-1:0]   payPc_q, payPc_d;
  logic [DATA_WIDTH-1:0] payImm_q, payImm_d;
  logic [PC_WIDTH-1:0]   payPred_q, payPred_d;
  logic [TAG_WIDTH-1:0]  payRob_q, payRob_d;

  logic [ENTRY_NUM-1:0]  readyVec, grant, freeOneHot;
  logic                  anyReady, issue, dpReady, dpFire;
  logic                  dpRdy1, dpRdy2;
  logic [DATA_WIDTH-1:0] dpSrc1, dpSrc2;

  assign readyVec   = valid_q & src1Rdy_q & src2Rdy_q;
  assign freeOneHot = ~valid_q & (valid_q + ENTRY_NUM'(1));
  assign dpReady    = ~(&valid_q);
  assign dpFire     = bus.i_dp_vld & dpReady & ~bus.i_flush;
  assign issue      = anyReady & bus.i_ex_accessable & ~bus.i_flush;

  rs_oldest_sel #(
    .ENTRY_NUM(ENTRY_NUM)
  ) u_oldest_sel (
    .ready_i(readyVec),
    .age_i  (age_q),
    .grant_o(grant),
    .any_o  (anyReady)
  );

  // A source broadcast on the CDB in the dispatch cycle is captured directly.
  assign dpRdy1 = bus.i_dp_src1_rdy | (bus.i_cdb_vld & (bus.i_cdb_tag == bus.i_dp_src1_tag));
  assign dpRdy2 = bus.i_dp_src2_rdy | (bus.i_cdb_vld & (bus.i_cdb_tag == bus.i_dp_src2_tag));
  assign dpSrc1 = bus.i_dp_src1_rdy ? bus.i_dp_src1 : bus.i_cdb_data;
  assign dpSrc2 = bus.i_dp_src2_rdy ? bus.i_dp_src2 : bus.i_cdb_data;

  always_comb begin
    valid_d   = valid_q;
    age_d     = age_q;
    isJal_d   = isJal_q;
    isJalr_d  = isJalr_q;
    src1Rdy_d = src1Rdy_q;
    src2Rdy_d = src2Rdy_q;
    op_d      = op_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    tag1_d    = tag1_q;
    tag2_d    = tag2_q;
    pc_d      = pc_q;
    imm_d     = imm_q;
    pred_d    = pred_q;
    rob_d     = rob_q;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (valid_q[i] && !src1Rdy_q[i] && bus.i_cdb_vld && (tag1_q[i] == bus.i_cdb_tag)) begin
        src1Rdy_d[i] = 1'b1;
        src1_d[i]    = bus.i_cdb_data;
      end
      if (valid_q[i] && !src2Rdy_q[i] && bus.i_cdb_vld && (tag2_q[i] == bus.i_cdb_tag)) begin
        src2Rdy_d[i] = 1'b1;
        src2_d[i]    = bus.i_cdb_data;
      end
      if (issue && grant[i]) begin
        valid_d[i] = 1'b0;
      end
      // New entry is younger than everything live; its column is wiped so
      // stale bits from a previous occupant never make it look older.
      if (dpFire && freeOneHot[i]) begin
        valid_d[i]   = 1'b1;
        isJal_d[i]   = bus.i_dp_is_jal;
        isJalr_d[i]  = bus.i_dp_is_jalr;
        op_d[i]      = bus.i_dp_alu_op_sel;
        src1Rdy_d[i] = dpRdy1;
        src2Rdy_d[i] = dpRdy2;
        src1_d[i]    = dpSrc1;
        src2_d[i]    = dpSrc2;
        tag1_d[i]    = bus.i_dp_src1_tag;
        tag2_d[i]    = bus.i_dp_src2_tag;
        pc_d[i]      = bus.i_dp_pc;
        imm_d[i]     = bus.i_dp_imm;
        pred_d[i]    = bus.i_dp_pred_jmpaddr;
        rob_d[i]     = bus.i_dp_rob_tag;
        age_d[i]     = valid_q & ~(grant & {ENTRY_NUM{issue}});
        for (int k = 0; k < ENTRY_NUM; k++) begin
          age_d[k][i] = 1'b0;
        end
      end
    end
    if (bus.i_flush) begin
      valid_d = '0;
      age_d   = '0;
    end
  end

  always_comb begin
    payJal_d  = payJal_q;
    payJalr_d = payJalr_q;
    payOp_d   = payOp_q;
    payRs1_d  = payRs1_q;
    payRs2_d  = payRs2_q;
    payPc_d   = payPc_q;
    payImm_d  = payImm_q;
    payPred_d = payPred_q;
    payRob_d  = payRob_q;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (issue && grant[i]) begin
        payJal_d  = isJal_q[i];
        payJalr_d = isJalr_q[i];
        payOp_d   = op_q[i];
        payRs1_d  = src1_q[i];
        payRs2_d  = src2_q[i];
        payPc_d   = pc_q[i];
        payImm_d  = imm_q[i];
        payPred_d = pred_q[i];
        payRob_d  = rob_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= '0;
      age_q     <= '0;
      payJal_q  <= 1'b0;
      payJalr_q <= 1'b0;
      payOp_q   <= '0;
      payRs1_q  <= '0;
      payRs2_q  <= '0;
      payPc_q   <= '0;
      payImm_q  <= '0;
      payPred_q <= '0;
      payRob_q  <= '0;
    end else begin
      valid_q   <= valid_d;
      age_q     <= age_d;
      payJal_q  <= payJal_d;
      payJalr_q <= payJalr_d;
      payOp_q   <= payOp_d;
      payRs1_q  <= payRs1_d;
      payRs2_q  <= payRs2_d;
      payPc_q   <= payPc_d;
      payImm_q  <= payImm_d;
      payPred_q <= payPred_d;
      payRob_q  <= payRob_d;
    end
  end

  // Entry contents are qualified by valid_q, so they need no reset.
  always_ff @(posedge clk) begin
    isJal_q   <= isJal_d;
    isJalr_q  <= isJalr_d;
    src1Rdy_q <= src1Rdy_d;
    src2Rdy_q <= src2Rdy_d;
    op_q      <= op_d;
    src1_q    <= src1_d;
    src2_q    <= src2_d;
    tag1_q    <= tag1_d;
    tag2_q    <= tag2_d;
    pc_q      <= pc_d;
    imm_q     <= imm_d;
    pred_q    <= pred_d;
    rob_q     <= rob_d;
  end

  assign bus.o_dp_ready     = dpReady;
  assign bus.o_is_vld       = issue;
  assign bus.o_is_jal       = payJal_q;
  assign bus.o_is_jalr      = payJalr_q;
  assign bus.o_alu_op_sel   = payOp_q;
  assign bus.o_rs1          = payRs1_q;
  assign bus.o_rs2          = payRs2_q;
  assign bus.o_pc           = payPc_q;
  assign bus.o_imm          = payImm_q;
  assign bus.o_pred_jmpaddr = payPred_q;
  assign bus.o_rob_tag      = payRob_q;

endmodule

// File: tb/tb_rs_branch.sv
// Scoreboard bench for rs_branch: an in-order list model predicts each cycle's
// issue/ready outputs and the issued payload; a negedge monitor checks them.
module tb_rs_branch;
  import rs_branch_pkg::*;

  localparam int N = RS_BR_ENTRY_NUM;

  typedef struct packed {
    logic                       jal;
    logic                       jalr;
    logic [ALU_OP_SEL-1:0]      op;
    logic [RV32_DATA_WIDTH-1:0] rs1;
    logic [RV32_DATA_WIDTH-1:0] rs2;
    logic [RV32_PC_WIDTH-1:0]   pc;
    logic [RV32_DATA_WIDTH-1:0] imm;
    logic [RV32_PC_WIDTH-1:0]   pred;
    logic [RS_BR_TAG_WIDTH-1:0] rob;
  } pay_t;

  typedef struct {
    pay_t                       p;
    logic                       r1;
    logic                       r2;
    logic [RS_BR_TAG_WIDTH-1:0] t1;
    logic [RS_BR_TAG_WIDTH-1:0] t2;
  } ent_t;

  typedef struct packed {
    logic chk;
    logic rst;
    logic isVld;
    logic dpRdy;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  rs_branch_if bus ();

  rs_branch dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // The model keeps live uops in dispatch order, so the oldest is always first.
  ent_t model[$];
  pay_t payQ[$];
  rec_t recQ[$];
  int   vectors = 0;
  int   miscompares = 0;
  pay_t held = '0;
  logic heldOk = 1'b0;
  rec_t mr;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic pay_t dutPay();
    pay_t p;
    p.jal  = bus.o_is_jal;
    p.jalr = bus.o_is_jalr;
    p.op   = bus.o_alu_op_sel;
    p.rs1  = bus.o_rs1;
    p.rs2  = bus.o_rs2;
    p.pc   = bus.o_pc;
    p.imm  = bus.o_imm;
    p.pred = bus.o_pred_jmpaddr;
    p.rob  = bus.o_rob_tag;
    return p;
  endfunction

  // Predict this cycle's outputs, then advance the model across the clock edge.
  task automatic applyStimulus();
    rec_t r;
    int   sel;
    ent_t e;
    r   = '0;
    sel = -1;
    if (!rst_n) begin
      r.rst = 1'b1;
      model.delete();
      recQ.push_back(r);
    end else begin
      r.chk   = 1'b1;
      r.dpRdy = (model.size() < N);
      foreach (model[i]) if (sel < 0 && model[i].r1 && model[i].r2) sel = i;
      r.isVld = (sel >= 0) && bus.i_ex_accessable && !bus.i_flush;
      recQ.push_back(r);
      if (r.isVld) begin
        payQ.push_back(model[sel].p);
        model.delete(sel);
      end
      if (bus.i_flush) begin
        model.delete();
      end else begin
        foreach (model[i]) begin
          e = model[i];
          if (bus.i_cdb_vld && !e.r1 && e.t1 == bus.i_cdb_tag) begin
            e.r1 = 1'b1; e.p.rs1 = bus.i_cdb_data;
          end
          if (bus.i_cdb_vld && !e.r2 && e.t2 == bus.i_cdb_tag) begin
            e.r2 = 1'b1; e.p.rs2 = bus.i_cdb_data;
          end
          model[i] = e;
        end
        if (bus.i_dp_vld && r.dpRdy) begin
          e.p.jal  = bus.i_dp_is_jal;
          e.p.jalr = bus.i_dp_is_jalr;
          e.p.op   = bus.i_dp_alu_op_sel;
          e.p.pc   = bus.i_dp_pc;
          e.p.imm  = bus.i_dp_imm;
          e.p.pred = bus.i_dp_pred_jmpaddr;
          e.p.rob  = bus.i_dp_rob_tag;
          e.t1     = bus.i_dp_src1_tag;
          e.t2     = bus.i_dp_src2_tag;
          e.r1     = bus.i_dp_src1_rdy || (bus.i_cdb_vld && bus.i_cdb_tag == bus.i_dp_src1_tag);
          e.r2     = bus.i_dp_src2_rdy || (bus.i_cdb_vld && bus.i_cdb_tag == bus.i_dp_src2_tag);
          e.p.rs1  = bus.i_dp_src1_rdy ? bus.i_dp_src1 : bus.i_cdb_data;
          e.p.rs2  = bus.i_dp_src2_rdy ? bus.i_dp_src2 : bus.i_cdb_data;
          model.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_dp_vld  = 1'b0;
    bus.i_cdb_vld = 1'b0;
    bus.i_flush   = 1'b0;
  endtask

  task automatic setDp(input logic r1, input logic [5:0] t1, input logic [31:0] s1,
                       input logic r2, input logic [5:0] t2, input logic [31:0] s2,
                       input logic [31:0] pc, input logic [5:0] rob);
    bus.i_dp_vld          = 1'b1;
    bus.i_dp_is_jal       = 1'b0;
    bus.i_dp_is_jalr      = 1'b0;
    bus.i_dp_alu_op_sel   = BR_BEQ;
    bus.i_dp_src1_rdy     = r1;
    bus.i_dp_src1_tag     = t1;
    bus.i_dp_src1         = s1;
    bus.i_dp_src2_rdy     = r2;
    bus.i_dp_src2_tag     = t2;
    bus.i_dp_src2         = s2;
    bus.i_dp_pc           = pc;
    bus.i_dp_imm          = 32'h10;
    bus.i_dp_pred_jmpaddr = pc + 32'h10;
    bus.i_dp_rob_tag      = rob;
  endtask

  task automatic cdb(input logic [5:0] tag, input logic [31:0] data);
    bus.i_cdb_vld  = 1'b1;
    bus.i_cdb_tag  = tag;
    bus.i_cdb_data = data;
  endtask

  // Monitor: one prediction per cycle; payload is checked the cycle after issue
  // and for as long as it is expected to hold.
  always @(negedge clk) begin
    if (recQ.size() > 0) begin
      mr = recQ.pop_front();
      if (mr.rst) begin
        held   = '0;
        heldOk = 1'b1;
      end else if (mr.chk) begin
        if (heldOk) checkOutput("payload", 256'(dutPay()), 256'(held));
        checkOutput("is_vld", 256'(bus.o_is_vld), 256'(mr.isVld));
        checkOutput("dp_ready", 256'(bus.o_dp_ready), 256'(mr.dpRdy));
        if (mr.isVld && payQ.size() > 0) held = payQ.pop_front();
      end
    end
  end

  initial begin
    idle();
    setDp(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 32'd0, 6'd0);
    bus.i_dp_vld        = 1'b0;
    bus.i_cdb_tag       = '0;
    bus.i_cdb_data      = '0;
    bus.i_ex_accessable = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    repeat (2) applyStimulus();
    rst_n = 1'b1;

    // Single ready branch issues the cycle after dispatch.
    setDp(1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd5, 32'h100, 6'd1);
    applyStimulus();
    idle();
    repeat (3) applyStimulus();

    // Wakeup via CDB two cycles after dispatch, then same-cycle bypass.
    setDp(1'b1, 6'd0, 32'd9, 1'b0, 6'd7, 32'd0, 32'h200, 6'd2);
    applyStimulus();
    idle();
    applyStimulus();
    cdb(6'd7, 32'h55);
    applyStimulus();
    idle();
    repeat (2) applyStimulus();
    setDp(1'b0, 6'd7, 32'd0, 1'b1, 6'd0, 32'd3, 32'h240, 6'd3);
    cdb(6'd7, 32'h66);
    applyStimulus();
    idle();
    repeat (2) applyStimulus();

    // Three ready entries held back, then released in age order.
    bus.i_ex_accessable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      setDp(1'b1, 6'd0, 32'(k), 1'b1, 6'd0, 32'(k + 10), 32'h300 + 32'(k * 4), 6'(4 + k));
      applyStimulus();
    end
    idle();
    applyStimulus();
    bus.i_ex_accessable = 1'b1;
    repeat (4) applyStimulus();

    // Fill with blocked entries, try a fifth, then wake entry 2.
    for (int k = 0; k < 5; k++) begin
      setDp(1'b0, 6'(10 + k), 32'd0, 1'b1, 6'd0, 32'd1, 32'h400 + 32'(k * 4), 6'(10 + k));
      applyStimulus();
    end
    idle();
    cdb(6'd12, 32'hABC);
    applyStimulus();
    idle();
    repeat (2) applyStimulus();
    bus.i_flush = 1'b1;
    applyStimulus();
    idle();
    applyStimulus();

    // Flush with two ready entries pending; earlier payload must persist.
    setDp(1'b1, 6'd0, 32'h77, 1'b1, 6'd0, 32'h78, 32'h500, 6'd20);
    applyStimulus();
    idle();
    applyStimulus();
    bus.i_ex_accessable = 1'b0;
    setDp(1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 32'h2, 32'h504, 6'd21);
    applyStimulus();
    setDp(1'b1, 6'd0, 32'h3, 1'b1, 6'd0, 32'h4, 32'h508, 6'd22);
    applyStimulus();
    idle();
    bus.i_ex_accessable = 1'b1;
    bus.i_flush = 1'b1;
    applyStimulus();
    idle();
    repeat (2) applyStimulus();

    // Synchronous reset with three live entries.
    bus.i_ex_accessable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      setDp(1'b1, 6'd0, 32'h9, 1'b1, 6'd0, 32'h9, 32'h600 + 32'(k * 4), 6'(30 + k));
      applyStimulus();
    end
    idle();
    rst_n = 1'b0;
    applyStimulus();
    rst_n = 1'b1;
    bus.i_ex_accessable = 1'b1;
    repeat (3) applyStimulus();

    // Randomized traffic with a small tag space so wakeups collide often.
    for (int c = 0; c < 800; c++) begin
      bus.i_dp_vld          = ($urandom_range(0, 99) < 55);
      bus.i_dp_is_jal       = ($urandom_range(0, 9) == 0);
      bus.i_dp_is_jalr      = ($urandom_range(0, 9) == 0);
      bus.i_dp_alu_op_sel   = 4'($urandom_range(0, 15));
      bus.i_dp_src1_rdy     = ($urandom_range(0, 99) < 60);
      bus.i_dp_src2_rdy     = ($urandom_range(0, 99) < 60);
      bus.i_dp_src1         = $urandom;
      bus.i_dp_src2         = $urandom;
      bus.i_dp_src1_tag     = 6'($urandom_range(0, 7));
      bus.i_dp_src2_tag     = 6'($urandom_range(0, 7));
      bus.i_dp_pc           = $urandom;
      bus.i_dp_imm          = $urandom;
      bus.i_dp_pred_jmpaddr = $urandom;
      bus.i_dp_rob_tag      = 6'($urandom_range(0, 63));
      bus.i_cdb_vld         = ($urandom_range(0, 99) < 40);
      bus.i_cdb_tag         = 6'($urandom_range(0, 7));
      bus.i_cdb_data        = $urandom;
      bus.i_flush           = ($urandom_range(0, 99) < 2);
      bus.i_ex_accessable   = ($urandom_range(0, 99) < 75);
      rst_n                 = ($urandom_range(0, 199) != 0);
      applyStimulus();
    end
    rst_n = 1'b1;
    idle();
    bus.i_ex_accessable = 1'b1;
    bus.i_flush = 1'b1;
    applyStimulus();
    idle();
    repeat (3) applyStimulus();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rs_branch.md
Name: rs_branch

Overview:
- Branch reservation station: the issue-side transmitter that feeds exunit_br.
- Buffers dispatched branch/jump uops until both source operands are ready, and captures operands from the common data bus (CDB).
- Each cycle, issues the oldest ready entry to the branch execution unit.
- Drives exunit_br's i_is_vld/payload interface and honours its o_accessable.

Parameters:
ENTRY_NUM, 4, number of RS entries (power of 2, ≥2)
TAG_WIDTH, 6, rename/ROB tag width used for wakeup
DATA_WIDTH, 32, operand width (matches `RV32_DATA_WIDTH)
PC_WIDTH, 32, PC width (matches `RV32_PC_WIDTH)
OP_WIDTH, 4, ALU op select width (matches `ALU_OP_SEL)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
i_dp_vld  in  1  dispatch request
o_dp_ready  out  1  at least one free entry
i_dp_is_jal / i_dp_is_jalr  in  1 each  jump type
i_dp_alu_op_sel  in  OP_WIDTH  compare op
i_dp_src1_rdy / i_dp_src2_rdy  in  1 each  operand already valid
i_dp_src1 / i_dp_src2  in  DATA_WIDTH each  operand value (valid when rdy)
i_dp_src1_tag / i_dp_src2_tag  in  TAG_WIDTH each  producer tag (when not rdy)
i_dp_pc  in  PC_WIDTH  branch PC
i_dp_imm  in  DATA_WIDTH  immediate
i_dp_pred_jmpaddr  in  PC_WIDTH  predicted target
i_dp_rob_tag  in  TAG_WIDTH  ROB index of the uop
i_cdb_vld  in  1  CDB broadcast valid
i_cdb_tag  in  TAG_WIDTH  CDB tag
i_cdb_data  in  DATA_WIDTH  CDB result
i_flush  in  1  misprediction flush; kill all entries
i_ex_accessable  in  1  from exunit_br o_accessable
o_is_vld  out  1  issue pulse (to i_is_vld)
o_is_jal, o_is_jalr, o_alu_op_sel, o_rs1, o_rs2, o_pc, o_imm, o_pred_jmpaddr, o_rob_tag  out  matching widths  issue payload register

Behaviour:
- Reset: all entry valid bits 0; age matrix cleared; o_is_vld=0; all payload outputs 0; o_dp_ready=1 the first cycle after reset.
- Dispatch handshake:
  - Fires when i_dp_vld && o_dp_ready && !i_flush.
  - Writes the lowest-index free entry, which becomes valid next cycle.
  - o_dp_ready is computed from current valid bits only; an entry freed by a same-cycle issue is not counted.
- Dispatch bypass: if i_cdb_vld and i_cdb_tag matches a not-ready source tag of the dispatching uop, that source is written as ready with i_cdb_data.
- Wakeup: every cycle, each valid entry with a not-ready source whose tag equals i_cdb_tag (with i_cdb_vld) captures i_cdb_data and sets the ready bit at the clock edge.
- Ready = valid && src1_rdy && src2_rdy, evaluated on registered state only:
  - An entry woken in cycle N is issuable in N+1.
  - An entry dispatched in cycle N is issuable in N+1 at earliest.
- Age ordering: an ENTRY_NUM×ENTRY_NUM age matrix. On dispatch, row[new]=all currently valid entries (they are older). The selected entry is the ready entry with no older ready entry.
- Issue in cycle N requires a ready entry && i_ex_accessable && !i_flush:
  - o_is_vld=1 combinationally in cycle N.
  - The selected entry's valid bit is cleared at the end of N.
  - The payload register captures that entry at the end of N.
- Payload timing: o_rs1…o_rob_tag are stable in cycle N+1 (when exunit_br's busy is high) and hold until the next issue. They are not cleared when no issue occurs.
- Throughput: at most 1 issue and 1 dispatch per cycle; back-to-back issues allowed.
- Flush:
  - i_flush in cycle N clears all valid bits and the age matrix at the end of N.
  - o_is_vld is forced 0 in N, and dispatch in N is dropped.
  - An issue from cycle N-1 is not cancelled; its payload stays valid in N.
- Full (all valid): o_dp_ready=0, and a dispatch attempt has no effect.
- Empty: o_is_vld=0.
- Simultaneous CDB wakeup and issue of the same entry cannot occur, because issue uses registered ready.

Decomposition:
- Widths come from constants.vh (`RV32_DATA_WIDTH, `RV32_PC_WIDTH, `ALU_OP_SEL). Add `RS_BR_ENTRY_NUM and `TAG_WIDTH there.
- One sub-module, rs_oldest_sel: takes the ready vector and age matrix, and returns a one-hot grant plus an any-grant flag. It is purely combinational.

Test Plan:
1. Dispatch A (both rdy, rs1=5, rs2=5, BEQ, pc=0x100) into an empty RS with accessable=1 → o_is_vld=1 the next cycle; following cycle o_rs1=5, o_pc=0x100, o_rob_tag=A.
2. Dispatch B with src2 tag 7 not ready; CDB tag 7, data 0x55 two cycles later → issue exactly one cycle after the CDB cycle with o_rs2=0x55. Dispatch with a same-cycle CDB tag 7 → issue next cycle.
3. Dispatch C, D, E (all ready, in order) while i_ex_accessable=0; release → issues in order C, D, E on three consecutive cycles.
4. Fill 4 entries with blocked operands → o_dp_ready=0; a 5th dispatch is ignored. Wake entry 2 → it issues, and o_dp_ready=1 the cycle after.
5. Two ready entries plus i_flush → no o_is_vld that cycle; RS empty next cycle; o_dp_ready=1; payload from the prior issue unchanged.
6. Assert rst_n=0 mid-operation with 3 valid entries → o_is_vld=0 and payload=0 after the edge; no issue until a new dispatch.
